// File: rtl/sram_parity_writer.sv
// rtl/sram_parity_writer.sv - SRAM write sequencer with per-byte even parity generation
//
// Accepts one write request at a time and plays it out to an asynchronous
// SRAM as SETUP (address/data settle), STROBE (we high for WR_CYCLES cycles)
// and HOLD (we low, address/data still held). Each byte carries a parity bit
// chosen so the 9-bit byte-plus-parity group has even parity.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_addr/req_data/req_be request word address, data, byte enables
//   sram_addr/sram_data      registered SRAM address and data
//   sram_parity/sram_be      registered parity bits and byte enables
//   sram_we                  registered SRAM write strobe
//   busy                     high whenever a write is in progress
//   wr_count                 count of completed writes (wraps)

module sram_parity_writer #(
    parameter int ADDR_W    = 10,
    parameter int WR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [3:0]        req_be,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_data,
    output logic [3:0]        sram_parity,
    output logic [3:0]        sram_be,
    output logic              sram_we,
    output logic              busy,
    output logic [15:0]       wr_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Counter value on the final strobe cycle.
    localparam logic [3:0] STROBE_LAST = 4'(WR_CYCLES - 1);

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         data_q;
    logic [3:0]          parity_q;
    logic [3:0]          be_q;
    logic                we_q;
    logic [15:0]         wr_count_q;

    logic [3:0]          parity_d;
    logic                handshake;

    // Parity bit equals the XOR of its byte, making each group even.
    always_comb begin
        parity_d = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            parity_d[i] = ^req_data[8*i +: 8];
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign handshake = req_valid && req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            data_q     <= 32'd0;
            parity_q   <= 4'd0;
            be_q       <= 4'd0;
            we_q       <= 1'b0;
            wr_count_q <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        addr_q   <= req_addr;
                        data_q   <= req_data;
                        parity_q <= parity_d;
                        be_q     <= req_be;
                        // An all-zero byte mask writes nothing: latch it but
                        // never start an SRAM cycle.
                        if (req_be != 4'b0000) begin
                            state_q <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    state_q <= STROBE;
                    we_q    <= 1'b1;
                    cnt_q   <= 4'd0;
                end
                STROBE: begin
                    if (cnt_q == STROBE_LAST) begin
                        state_q <= HOLD;
                        we_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                HOLD: begin
                    state_q    <= IDLE;
                    wr_count_q <= wr_count_q + 16'd1;
                end
                default: begin
                    state_q <= IDLE;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign sram_addr   = addr_q;
    assign sram_data   = data_q;
    assign sram_parity = parity_q;
    assign sram_be     = be_q;
    assign sram_we     = we_q;
    assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_sram_parity_writer.sv
// tb/tb_sram_parity_writer.sv - directed self-checking bench for sram_parity_writer

module tb_sram_parity_writer;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_be;
    logic [9:0]  sram_addr;
    logic [31:0] sram_data;
    logic [3:0]  sram_parity;
    logic [3:0]  sram_be;
    logic        sram_we;
    logic        busy;
    logic [15:0] wr_count;

    int total = 0;
    int bad   = 0;

    sram_parity_writer #(.ADDR_W(10), .WR_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_be     (req_be),
        .sram_addr  (sram_addr),
        .sram_data  (sram_data),
        .sram_parity(sram_parity),
        .sram_be    (sram_be),
        .sram_we    (sram_we),
        .busy       (busy),
        .wr_count   (wr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Handshake at the posedge ending cycle 0, then sample cycles 1..7 at
    // their negedges. Index 0 of each trace is unused.
    task automatic run_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be,
                             output logic [7:0] we_tr, output logic [7:0] rdy_tr,
                             output logic [7:0] busy_tr);
        we_tr = 8'd0; rdy_tr = 8'd0; busy_tr = 8'd0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_data = d; req_be = be;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            we_tr[i]   = sram_we;
            rdy_tr[i]  = req_ready;
            busy_tr[i] = busy;
        end
    endtask

    logic [7:0]  we_tr, rdy_tr, busy_tr;
    logic [31:0] data_a, data_b;
    logic        stable;
    logic        lane_err;
    int          waited;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = 10'd0; req_data = 32'd0; req_be = 4'd0;

        // Reset state, checked before any clock edge.
        #2;
        check("rst_ready", req_ready, 1);
        check("rst_we", sram_we, 0);
        check("rst_busy", busy, 0);
        check("rst_count", wr_count, 0);
        check("rst_outs", {sram_addr, sram_be, sram_parity} | sram_data, 0);
        @(negedge clk);
        rst = 1'b0;

        // Full write: we high in cycles 2-3, HOLD in 4, ready again in 5.
        run_write(10'h005, 32'hFFFF_FFFF, 4'b1111, we_tr, rdy_tr, busy_tr);
        check("w1_we_trace", we_tr, 8'b0000_1100);
        check("w1_rdy_trace", rdy_tr, 8'b1110_0000);
        check("w1_busy_trace", busy_tr, 8'b0001_1110);
        check("w1_addr", sram_addr, 10'h005);
        check("w1_data", sram_data, 32'hFFFF_FFFF);
        check("w1_parity", sram_parity, 4'b0000);
        check("w1_count", wr_count, 1);

        run_write(10'h010, 32'h0000_0001, 4'b1111, we_tr, rdy_tr, busy_tr);
        check("p_0001", sram_parity, 4'b0001);
        run_write(10'h011, 32'h0101_0101, 4'b1111, we_tr, rdy_tr, busy_tr);
        check("p_1111", sram_parity, 4'b1111);
        run_write(10'h012, 32'h80FF_0300, 4'b1111, we_tr, rdy_tr, busy_tr);
        check("p_1000", sram_parity, 4'b1000);
        check("count_4", wr_count, 4);

        // Empty byte mask: no write cycle, counter unchanged.
        run_write(10'h020, 32'hDEAD_BEEF, 4'b0000, we_tr, rdy_tr, busy_tr);
        check("be0_we_trace", we_tr, 8'd0);
        check("be0_rdy_trace", rdy_tr, 8'b1111_1110);
        check("be0_count", wr_count, 4);
        check("be0_sram_be", sram_be, 4'b0000);

        // Back-to-back: req_valid held; second request waits for cycle 5.
        data_a = 32'hA5A5_0F0F;
        data_b = 32'h1234_5678;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 10'h030; req_data = data_a; req_be = 4'b1111;
        @(posedge clk);
        #1 req_addr = 10'h031; req_data = data_b;
        stable = 1'b1;
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            if (sram_data !== data_a || req_ready !== 1'b0) stable = 1'b0;
        end
        check("b2b_first_stable", stable, 1);
        @(negedge clk);
        check("b2b_ready_c5", req_ready, 1);
        check("b2b_data_c5", sram_data, data_a);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("b2b_second_busy", busy, 1);
        check("b2b_second_data", sram_data, data_b);
        waited = 0;
        while (busy && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("b2b_done_in_time", (waited < 20), 1);
        check("b2b_count", wr_count, 6);

        // Partial write on lanes 0 and 2, with a lane parity checker.
        run_write(10'h040, 32'h1122_3344, 4'b0101, we_tr, rdy_tr, busy_tr);
        check("pw_sram_be", sram_be, 4'b0101);
        check("pw_parity", sram_parity, 4'b0000);
        check("pw_data", sram_data, 32'h1122_3344);
        lane_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (sram_be[i] && ((^sram_data[8*i +: 8]) ^ sram_parity[i])) lane_err = 1'b1;
        end
        check("pw_lane_err", lane_err, 0);

        // Reset during STROBE: outputs drop with no clock edge.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 10'h050; req_data = 32'hCAFE_F00D; req_be = 4'b1111;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_we_before", sram_we, 1);
        #1 rst = 1'b1;
        #1;
        check("mid_we", sram_we, 0);
        check("mid_busy", busy, 0);
        check("mid_count", wr_count, 0);
        check("mid_ready", req_ready, 1);
        check("mid_data", sram_data, 0);

        // First edge after reset release accepts a request.
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b1; req_addr = 10'h3FF; req_data = 32'h0000_00FF; req_be = 4'b0001;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("post_rst_busy", busy, 1);
        check("post_rst_addr", sram_addr, 10'h3FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
